ula_driver: RTL and testbench
=============================

ULA_DRIVER -- requirements
Module: ula_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width.
REQ-002 SHALL have parameter SETTLE, default 1, range 1..15, cycles operands are held before result capture.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk input 1 (all state on rising edge); rst_n input 1.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output 1  command accepted when high with cmd_valid.
REQ-006 cmd_a, cmd_b  input  WIDTH  operands; cmd_op input 2, operation code; cmd_exp input WIDTH, expected result.
REQ-007 ula_a, ula_b  output WIDTH, ula_op output 2: registered drive to top_ula A/B/op.
REQ-008 ula_c  input  WIDTH  result from top_ula C.
REQ-009 rsp_valid output 1; rsp_ready input 1; rsp_c output WIDTH, captured result; rsp_err output 1, rsp_c != expected.
REQ-010 err_count output 8, saturating mismatch count; busy output 1, high when not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, DRIVE, RESP.
REQ-012 cmd_ready SHALL equal (state == IDLE); busy SHALL equal its inverse.
REQ-013 IDLE: on cmd_valid && cmd_ready at edge k, SHALL register cmd_a/cmd_b/cmd_op into ula_a/ula_b/ula_op, store cmd_exp, load settle counter with SETTLE, enter DRIVE.
REQ-014 DRIVE: counter SHALL decrement each edge; on the edge it reaches 0 (edge k+SETTLE) SHALL capture ula_c into rsp_c, set rsp_err = (ula_c != stored expected), enter RESP.
REQ-015 RESP: rsp_valid SHALL be high; rsp_c/rsp_err SHALL hold stable until rsp_valid && rsp_ready, after which state SHALL return to IDLE on that edge.
REQ-016 Latency SHALL be exactly SETTLE cycles from command acceptance to rsp_valid high; minimum period between acceptances SETTLE+2 cycles with rsp_ready held high.
REQ-017 rsp_ready high in the first RESP cycle SHALL complete the response in that cycle.
REQ-018 cmd_valid while busy SHALL be ignored; command inputs SHALL NOT affect ula_* outside IDLE acceptance.
REQ-019 ula_a/ula_b/ula_op SHALL hold last issued values after completion until the next acceptance.
REQ-020 err_count SHALL increment by 1 on capture with mismatch, saturating at 255 (no wrap).
REQ-021 rsp_err SHALL be cleared on return to IDLE; rsp_c SHALL retain last value.

Reset
REQ-022 rst_n low SHALL asynchronously force state IDLE, ula_a/ula_b/ula_op = 0, rsp_c = 0, rsp_valid = 0, rsp_err = 0, err_count = 0, settle counter = 0.
REQ-023 Reset during DRIVE or RESP SHALL abort the transaction with no response issued; first acceptance possible on the first edge after rst_n rises.

Structure
REQ-024 Package ula_pkg SHALL hold ULA_WIDTH = 16 and op codes OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11, shared with top_ula.
REQ-025 ula_driver SHALL NOT instantiate top_ula; the integration wrapper connects ula_a/ula_b/ula_op/ula_c to top_ula A/B/op/C; no sub-module inside ula_driver.

Verification
REQ-026 Bench SHALL instantiate ula_driver with top_ula, SETTLE=1, rsp_ready high.
REQ-027 A=0x0001, B=0x0009, op=OP_SUB, exp=0xFFF8 -> rsp_valid one cycle after acceptance, rsp_c=0xFFF8, rsp_err=0, err_count=0.
REQ-028 A=0x0009, B=0x0008, op=OP_AND, exp=0x0001 -> rsp_c=0x0008, rsp_err=1, err_count=1.
REQ-029 rsp_ready low 5 cycles after op=OP_OR, A=0x0002, B=0x0009 -> rsp_valid held, rsp_c=0x000B stable, cmd_ready low throughout; new cmd_valid ignored.
REQ-030 256 mismatching commands (A=0x0002, B=0x0009, op=OP_ADD, exp=0) -> err_count=255, no wrap.
REQ-031 rst_n low mid-DRIVE (SETTLE=4) -> all outputs 0 immediately, no rsp_valid; next command completes normally after 4 cycles.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg: definitions shared by the ULA driver and top_ula.
//   ULA_WIDTH  default operand/result width
//   OP_*       two-bit operation codes understood by top_ula
//   CNT_W      width of the driver's settle counter (SETTLE is 1..15)
//   ula_state_e driver FSM state encoding, also exported on state_dbg
package ula_pkg;

  localparam int unsigned ULA_WIDTH = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } ula_state_e;

endpackage

// File: rtl/top_ula.sv
// top_ula: combinational arithmetic/logic unit driven by ula_driver through
// the integration wrapper (or the bench).
//   a, b  operands (WIDTH)
//   op    operation code (OP_ADD / OP_SUB / OP_AND / OP_OR)
//   c     result (WIDTH), modulo 2**WIDTH for add/sub
module top_ula
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = ULA_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] c
);

  always_comb begin
    c = '0;
    case (op)
      OP_ADD:  c = a + b;
      OP_SUB:  c = a - b;
      OP_AND:  c = a & b;
      OP_OR:   c = a | b;
      default: c = '0;
    endcase
  end

endmodule

// File: rtl/ula_driver.sv
// ula_driver: takes one command at a time, drives the operands onto the
// external ULA, waits SETTLE cycles, captures the result, compares it with the
// expected value and returns it on a response handshake.
//
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_a, cmd_b, cmd_op      operands and op code for the ULA
//   cmd_exp                   expected ULA result for this command
//   ula_a, ula_b, ula_op      registered drive to the ULA (held between commands)
//   ula_c                     result from the ULA
//   rsp_valid/rsp_ready       response handshake
//   rsp_c, rsp_err            captured result and mismatch flag
//   err_count                 saturating count of mismatching captures
//   busy                      high whenever a command is in flight
//   state_dbg                 current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. cmd_ready depends only on state, never on cmd_valid. Once
// rsp_valid rises, rsp_c/rsp_err stay stable until the transfer; rsp_ready may
// be high early, which completes the response in its first cycle.
//
// SETTLE must lie in 1..15 (it is loaded into a 4-bit counter).
module ula_driver
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH  = ULA_WIDTH,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_exp,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic [1:0]       ula_op,
  input  logic [WIDTH-1:0] ula_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_err,
  output logic [7:0]       err_count,
  output logic             busy,
  output ula_state_e       state_dbg
);

  ula_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] exp_q;
  logic             accept, capture, done;
  logic             mismatch;

  assign mismatch = (ula_c != exp_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // The counter reaches 0 on this edge when it currently holds 1.
        // "<= 1" also rescues a stuck 0 rather than hanging in DRIVE.
        if (cnt_q <= CNT_W'(1)) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: operand drive, settle counter, result capture, error count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ula_a     <= '0;
      ula_b     <= '0;
      ula_op    <= '0;
      exp_q     <= '0;
      cnt_q     <= '0;
      rsp_c     <= '0;
      rsp_err   <= 1'b0;
      err_count <= '0;
    end else begin
      if (accept) begin
        ula_a  <= cmd_a;
        ula_b  <= cmd_b;
        ula_op <= cmd_op;
        exp_q  <= cmd_exp;
        cnt_q  <= CNT_W'(SETTLE);
      end else if (state_q == ST_DRIVE && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (capture) begin
        rsp_c   <= ula_c;
        rsp_err <= mismatch;
        if (mismatch && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end

      // rsp_c keeps the last result; only the error flag is cleared.
      if (done) rsp_err <= 1'b0;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = (state_q == ST_RESP);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ula_driver.sv
module tb_ula_driver;
  import ula_pkg::*;

  localparam int W  = 16;
  localparam int SW = W + 1;  // {expected error flag, expected result}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n, rst4_n;
  always #5 clk = ~clk;

  // ---------------- DUT (SETTLE=1) + ULA ----------------
  logic           cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, busy;
  logic [W-1:0]   cmd_a, cmd_b, cmd_exp, ula_a, ula_b, ula_c, rsp_c;
  logic [1:0]     cmd_op, ula_op;
  logic [7:0]     err_count;
  ula_state_e     state_dbg;

  ula_driver #(.WIDTH(W), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_exp(cmd_exp),
    .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op), .ula_c(ula_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
    .rsp_err(rsp_err), .err_count(err_count), .busy(busy),
    .state_dbg(state_dbg)
  );
  top_ula #(.WIDTH(W)) ula (.a(ula_a), .b(ula_b), .op(ula_op), .c(ula_c));

  // ---------------- DUT (SETTLE=4) + ULA ----------------
  logic           cmd_valid4, cmd_ready4, rsp_valid4, rsp_ready4, rsp_err4, busy4;
  logic [W-1:0]   cmd_a4, cmd_b4, cmd_exp4, ula_a4, ula_b4, ula_c4, rsp_c4;
  logic [1:0]     cmd_op4, ula_op4;
  logic [7:0]     err_count4;
  ula_state_e     state_dbg4;

  ula_driver #(.WIDTH(W), .SETTLE(4)) dut4 (
    .clk(clk), .rst_n(rst4_n),
    .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
    .cmd_a(cmd_a4), .cmd_b(cmd_b4), .cmd_op(cmd_op4), .cmd_exp(cmd_exp4),
    .ula_a(ula_a4), .ula_b(ula_b4), .ula_op(ula_op4), .ula_c(ula_c4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_c(rsp_c4),
    .rsp_err(rsp_err4), .err_count(err_count4), .busy(busy4),
    .state_dbg(state_dbg4)
  );
  top_ula #(.WIDTH(W)) ula4 (.a(ula_a4), .b(ula_b4), .op(ula_op4), .c(ula_c4));

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference ALU behaviour
  function automatic logic [W-1:0] ula_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  // ---------------- scoreboard (SETTLE=1 DUT) ----------------
  logic [SW-1:0] exp_q[$];
  int            err_model = 0;

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        logic [SW-1:0] e;
        e = exp_q.pop_front();
        check("rsp_c", 32'(rsp_c), 32'(e[W-1:0]));
        check("rsp_err", 32'(rsp_err), 32'(e[W]));
        check("err_count", 32'(err_count), 32'(err_model));
      end
    end
  end

  // ---------------- driver tasks (SETTLE=1 DUT) ----------------
  // Offer one command; returns #1 after the acceptance edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic [W-1:0] exp);
    logic [W-1:0] c;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    c = ula_model(a, b, op);
    if (c != exp && err_model < 255) err_model++;
    exp_q.push_back({(c != exp), c});
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_exp = exp; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Cycles from acceptance until rsp_valid, bounded.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] op, input logic [W-1:0] exp);
    int lat;
    issue(a, b, op, exp);
    wait_rsp(lat);
    check("latency", 32'(lat), 32'd1);
    @(posedge clk); #1;  // handshake edge (rsp_ready high)
    check("idle_after", 32'(cmd_ready), 32'd1);
    check("err_cleared", 32'(rsp_err), 32'd0);
    check("ula_a_hold", 32'(ula_a), 32'(a));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int seen_valid;
    logic [W-1:0] c4;

    rst_n = 1'b0; rst4_n = 1'b0;
    cmd_valid = 0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_exp = '0; rsp_ready = 1'b1;
    cmd_valid4 = 0; cmd_a4 = '0; cmd_b4 = '0; cmd_op4 = '0; cmd_exp4 = '0; rsp_ready4 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ula_a", 32'(ula_a), 32'd0);
    check("rst_rsp_c", 32'(rsp_c), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; rst4_n = 1'b1;

    // Basic: SUB match, AND mismatch
    send(16'h0001, 16'h0009, OP_SUB, 16'hFFF8);
    check("sub_errcnt", 32'(err_count), 32'd0);
    send(16'h0009, 16'h0008, OP_AND, 16'h0001);
    check("and_errcnt", 32'(err_count), 32'd1);
    check("rsp_c_retained", 32'(rsp_c), 32'h0008);

    // A few random matching commands
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      logic [1:0]   ro;
      ra = W'($urandom_range(0, 16'hFFFF));
      rb = W'($urandom_range(0, 16'hFFFF));
      ro = 2'($urandom_range(0, 3));
      send(ra, rb, ro, ula_model(ra, rb, ro));
    end

    // Back-pressure: rsp_ready low for 5 cycles, new commands ignored
    rsp_ready = 1'b0;
    issue(16'h0002, 16'h0009, OP_OR, 16'h000B);
    wait_rsp(lat);
    check("or_latency", 32'(lat), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_a = W'($urandom_range(0, 16'hFFFF)); cmd_b = 16'h5555; cmd_op = OP_ADD;
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_c", 32'(rsp_c), 32'h000B);
      check("stall_rdy", 32'(cmd_ready), 32'd0);
      check("stall_ula_a", 32'(ula_a), 32'h0002);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_done", 32'(cmd_ready), 32'd1);
    check("stall_ula_b", 32'(ula_b), 32'h0009);
    check("stall_sb_drained", 32'(exp_q.size()), 32'd0);

    // Saturation: 256 mismatching commands
    for (int i = 0; i < 256; i++) send(16'h0002, 16'h0009, OP_ADD, 16'h0000);
    check("sat_errcnt", 32'(err_count), 32'd255);

    // SETTLE=4: one mismatching transaction, then reset mid-DRIVE
    c4 = ula_model(16'h0003, 16'h0004, OP_ADD);
    cmd_a4 = 16'h0003; cmd_b4 = 16'h0004; cmd_op4 = OP_ADD; cmd_exp4 = 16'h0000;
    cmd_valid4 = 1'b1;
    @(posedge clk); #1;
    cmd_valid4 = 1'b0;
    lat = 0;
    while (!rsp_valid4 && lat < 40) begin @(posedge clk); #1; lat++; end
    check("s4_latency", 32'(lat), 32'd4);
    check("s4_rsp_c", 32'(rsp_c4), 32'(c4));
    check("s4_rsp_err", 32'(rsp_err4), 32'd1);
    check("s4_errcnt", 32'(err_count4), 32'd1);
    @(posedge clk); #1;

    cmd_a4 = 16'h0010; cmd_b4 = 16'h0020; cmd_op4 = OP_OR; cmd_exp4 = 16'h0030;
    cmd_valid4 = 1'b1;
    @(posedge clk); #1;
    cmd_valid4 = 1'b0;
    @(posedge clk); #1;
    check("s4_busy", 32'(busy4), 32'd1);
    #2 rst4_n = 1'b0;
    #1;
    check("s4r_busy", 32'(busy4), 32'd0);
    check("s4r_ula_a", 32'(ula_a4), 32'd0);
    check("s4r_ula_b", 32'(ula_b4), 32'd0);
    check("s4r_ula_op", 32'(ula_op4), 32'd0);
    check("s4r_rsp_c", 32'(rsp_c4), 32'd0);
    check("s4r_errcnt", 32'(err_count4), 32'd0);
    check("s4r_rsp_valid", 32'(rsp_valid4), 32'd0);
    seen_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid4) seen_valid++;
    end
    check("s4r_no_rsp", 32'(seen_valid), 32'd0);
    @(posedge clk); #1;
    rst4_n = 1'b1;
    cmd_a4 = 16'h1234; cmd_b4 = 16'h0034; cmd_op4 = OP_SUB; cmd_exp4 = 16'h1200;
    cmd_valid4 = 1'b1;
    @(posedge clk); #1;
    cmd_valid4 = 1'b0;
    check("s4n_accepted", 32'(busy4), 32'd1);
    lat = 0;
    while (!rsp_valid4 && lat < 40) begin @(posedge clk); #1; lat++; end
    check("s4n_latency", 32'(lat), 32'd4);
    check("s4n_rsp_c", 32'(rsp_c4), 32'h1200);
    check("s4n_rsp_err", 32'(rsp_err4), 32'd0);
    check("s4n_errcnt", 32'(err_count4), 32'd0);
    @(posedge clk); #1;
    check("s4n_idle", 32'(cmd_ready4), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL timeout got %0d exp %0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
